// File: rtl/seq_display_pkg.sv
// seq_display_pkg: shared types and constants for the BCD seven-segment display driver
package seq_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } conv_state_t;

    localparam logic DIGIT_ONES = 1'b0;
    localparam logic DIGIT_TENS = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;

    localparam int CONV_STEPS = 6;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 after doubling
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to active-low abcdefg segment pattern, non-digits dark
module bcd_to_seg7
    import seq_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Lookup of the common-anode segment pattern for one digit
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seq_display_driver.sv
// seq_display_driver: sequential binary-to-BCD conversion feeding a multiplexed two-digit display
module seq_display_driver
    import seq_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] value,
    input  logic       sample_en,
    input  logic       blank,
    output logic       busy,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [2:0]  LAST_STEP    = 3'(CONV_STEPS - 1);

    conv_state_t r_state;
    logic        r_busy;
    logic [5:0]  r_shift;
    logic [7:0]  r_work;
    logic [2:0]  r_iter;
    logic [5:0]  r_cap;
    logic [5:0]  r_last;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;
    logic [15:0] r_refresh;
    logic        r_sel;
    logic [6:0]  r_seg;
    logic [1:0]  r_an;

    logic [7:0]  w_adj;
    logic [3:0]  w_digit;
    logic [6:0]  w_seg;

    assign w_adj   = {add3(r_work[7:4]), add3(r_work[3:0])};
    assign w_digit = (r_sel == DIGIT_TENS) ? r_tens : r_ones;

    bcd_to_seg7 u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Conversion FSM: capture a changed value, six add-3/shift steps, then commit the digits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_shift <= '0;
            r_work  <= '0;
            r_iter  <= '0;
            r_cap   <= '0;
            r_last  <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sample_en && value != r_last) begin
                        r_shift <= value;
                        r_cap   <= value;
                        r_work  <= '0;
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    {r_work, r_shift} <= {w_adj[6:0], r_shift, 1'b0};
                    r_iter            <= r_iter + 3'd1;
                    if (r_iter == LAST_STEP)
                        r_state <= COMMIT;
                end
                COMMIT: begin
                    r_tens  <= r_work[7:4];
                    r_ones  <= r_work[3:0];
                    r_last  <= r_cap;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running refresh timer alternating the lit digit every REFRESH_DIV cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_refresh <= '0;
            r_sel     <= DIGIT_ONES;
        end else if (r_refresh == REFRESH_LAST) begin
            r_refresh <= '0;
            r_sel     <= ~r_sel;
        end else begin
            r_refresh <= r_refresh + 16'd1;
        end
    end

    // Registered anode/segment drive with global blank and leading-zero suppression
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= 2'b11;
            r_seg <= SEG_BLANK;
        end else if (blank || (r_sel == DIGIT_TENS && r_tens == 4'd0)) begin
            r_an  <= 2'b11;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= (r_sel == DIGIT_TENS) ? 2'b01 : 2'b10;
            r_seg <= w_seg;
        end
    end

    assign busy     = r_busy;
    assign bcd_tens = r_tens;
    assign bcd_ones = r_ones;
    assign seg      = r_seg;
    assign an       = r_an;

endmodule

// File: tb/tb_seq_display_driver.sv
// tb_seq_display_driver: directed table-driven checks of conversion, scan, blanking and reset
module tb_seq_display_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] value;
    logic       sample_en;
    logic       blank;
    logic       busy;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] seg;
    logic [1:0] an;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0] val;
        logic [3:0] tens;
        logic [3:0] ones;
        logic [6:0] seg_t;
        logic [6:0] seg_o;
        logic [1:0] an_t;
    } vec_t;

    vec_t tbl [7];

    seq_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .sample_en (sample_en),
        .blank     (blank),
        .busy      (busy),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int bcnt;
        int ones_seen;
        int found;
        logic [1:0] prev;

        tbl[0] = '{6'd55, 4'd5, 4'd5, 7'h24, 7'h24, 2'b01};
        tbl[1] = '{6'd7,  4'd0, 4'd7, 7'h7F, 7'h0F, 2'b11};
        tbl[2] = '{6'd18, 4'd1, 4'd8, 7'h4F, 7'h00, 2'b01};
        tbl[3] = '{6'd42, 4'd4, 4'd2, 7'h4C, 7'h12, 2'b01};
        tbl[4] = '{6'd60, 4'd6, 4'd0, 7'h20, 7'h01, 2'b01};
        tbl[5] = '{6'd9,  4'd0, 4'd9, 7'h7F, 7'h04, 2'b11};
        tbl[6] = '{6'd34, 4'd3, 4'd4, 7'h06, 7'h4C, 2'b01};

        reset     = 1'b0;
        value     = 6'd0;
        sample_en = 1'b1;
        blank     = 1'b0;
        tick(2);
        chk("reset an", an, 2'b11);
        chk("reset seg", seg, 7'h7F);
        chk("reset busy", busy, 0);
        chk("reset tens", bcd_tens, 0);
        chk("reset ones", bcd_ones, 0);
        reset = 1'b1;
        tick(1);
        chk("first update an", an, 2'b10);
        chk("first update seg", seg, 7'h01);
        chk("value 0 no conversion", busy, 0);

        for (int i = 0; i < 7; i++) begin
            value = tbl[i].val;
            tick(1);
            chk("busy rises after capture", busy, 1);
            bcnt = 0;
            while (busy === 1'b1 && bcnt < 20) begin
                bcnt++;
                tick(1);
            end
            chk("busy length", bcnt, 7);
            chk("tens digit", bcd_tens, tbl[i].tens);
            chk("ones digit", bcd_ones, tbl[i].ones);
            tick(1);
            ones_seen = 0;
            for (int c = 0; c < 2 * DIV; c++) begin
                tick(1);
                if (an == 2'b10) begin
                    ones_seen++;
                    chk("ones seg", seg, tbl[i].seg_o);
                end else begin
                    chk("tens an", an, tbl[i].an_t);
                    chk("tens seg", seg, tbl[i].seg_t);
                end
            end
            chk("ones slot length", ones_seen, DIV);
        end

        prev  = an;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            tick(1);
            if (an == 2'b10 && prev != 2'b10) found = 1;
            prev = an;
        end
        chk("scan sync", found, 1);
        for (int k = 1; k <= 27; k++) begin
            if (k == 2) blank = 1'b1;
            if (k == 12) blank = 1'b0;
            tick(1);
            if (k >= 2 && k <= 11) begin
                chk("blank an", an, 2'b11);
                chk("blank seg", seg, 7'h7F);
            end else begin
                chk("scan an", an, (k % 8) < 4 ? 2'b10 : 2'b01);
                chk("scan seg", seg, (k % 8) < 4 ? 7'h4C : 7'h06);
            end
        end
        chk("blank left digits", {bcd_tens, bcd_ones}, 8'h34);

        value = 6'd13;
        tick(2);
        value = 6'd21;
        tick(6);
        chk("first commit tens", bcd_tens, 1);
        chk("first commit ones", bcd_ones, 3);
        chk("busy low after first commit", busy, 0);
        tick(1);
        chk("second capture busy", busy, 1);
        tick(6);
        chk("pre second commit", {bcd_tens, bcd_ones}, 8'h13);
        tick(1);
        chk("second commit", {bcd_tens, bcd_ones}, 8'h21);
        chk("busy low after second commit", busy, 0);

        sample_en = 1'b0;
        value     = 6'd50;
        tick(10);
        chk("sample_en hold busy", busy, 0);
        chk("sample_en hold digits", {bcd_tens, bcd_ones}, 8'h21);
        sample_en = 1'b1;
        tick(1);
        chk("sample_en release busy", busy, 1);
        tick(7);
        chk("sample_en conversion", {bcd_tens, bcd_ones}, 8'h50);

        value = 6'd63;
        tick(3);
        reset = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort digits", {bcd_tens, bcd_ones}, 8'h00);
        chk("abort an", an, 2'b11);
        chk("abort seg", seg, 7'h7F);
        tick(1);
        chk("no commit during reset", {busy, bcd_tens, bcd_ones}, 9'h000);
        reset = 1'b1;
        tick(1);
        chk("reconvert busy", busy, 1);
        tick(7);
        chk("reconvert 63", {bcd_tens, bcd_ones}, 8'h63);
        chk("reconvert busy low", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
